// File: rtl/slap_latency_meter.sv
// Measures cycles from a rising edge on ref_in to the matching rising edge on dly_in.
// Arm with start; done/timeout are registered one-cycle pulses and latency holds the last result.
module slap_latency_meter #(
  parameter int CNT_W   = 8,
  parameter int MAX_LAT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             ref_in,
  input  logic             dly_in,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] latency
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_LAT);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, latency_nx;
  logic             done_nx, timeout_nx;
  logic             ref_q, dly_q;
  logic             ref_rise, dly_rise;

  assign ref_rise = ref_in & ~ref_q;
  assign dly_rise = dly_in & ~dly_q;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ref_q   <= 1'b0;
      dly_q   <= 1'b0;
      latency <= '0;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      ref_q   <= ref_in;
      dly_q   <= dly_in;
      latency <= latency_nx;
      done    <= done_nx;
      timeout <= timeout_nx;
    end
  end

  // Exit checks come before the increment, so cnt stops at MAX_LAT and never wraps.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    latency_nx = latency;
    done_nx    = 1'b0;
    timeout_nx = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nx = ARM;
          cnt_nx   = '0;
        end
      end
      ARM: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (ref_rise && dly_rise) begin
          latency_nx = '0;
          done_nx    = 1'b1;
          state_nx   = IDLE;
        end else if (ref_rise) begin
          cnt_nx   = ONE_C;
          state_nx = MEASURE;
        end else if (cnt == MAX_C) begin
          timeout_nx = 1'b1;
          state_nx   = IDLE;
        end else begin
          cnt_nx = cnt + ONE_C;
        end
      end
      MEASURE: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (dly_rise) begin
          latency_nx = cnt;
          done_nx    = 1'b1;
          state_nx   = IDLE;
        end else if (cnt == MAX_C) begin
          timeout_nx = 1'b1;
          state_nx   = IDLE;
        end else begin
          cnt_nx = cnt + ONE_C;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_slap_latency_meter.sv
// Scoreboarded bench for slap_latency_meter with a selectable flop delay chain from ref_in to dly_in.
module tb_slap_latency_meter;

  localparam int CNT_W   = 8;
  localparam int MAX_LAT = 8;

  logic             clk = 1'b0;
  logic             rst, start, abort, ref_in, dly_in;
  logic             busy, done, timeout;
  logic [CNT_W-1:0] latency;

  typedef struct {
    bit is_to;
    int lat;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          sel      = 0;
  logic [15:0] sr       = '0;

  slap_latency_meter #(.CNT_W(CNT_W), .MAX_LAT(MAX_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .ref_in(ref_in), .dly_in(dly_in),
    .busy(busy), .done(done), .timeout(timeout), .latency(latency)
  );

  always #5 clk = ~clk;

  // Stage under test: sel flops between ref_in and dly_in (sel=0 ties them together).
  always @(posedge clk) sr <= {sr[14:0], ref_in};
  always_comb dly_in = (sel == 0) ? ref_in : sr[sel-1];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every done/timeout pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (done || timeout) begin
      check("pulse_exclusive", int'(done && timeout), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, timeout, done}, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind_timeout", int'(timeout), int'(e.is_to));
        check("pulse_latency", int'(latency), e.lat);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
  endtask

  // Count falling edges until a pulse is visible; -1 if none within the budget.
  task automatic wait_pulse(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done || timeout) begin
        n = i;
        break;
      end
    end
    #1;
  endtask

  task automatic run_meas(input string name, input int delay, input bit raise,
                          input bit exp_to, input int exp_lat, input int exp_n);
    int   n;
    exp_t e;
    sel     = delay;
    e.is_to = exp_to;
    e.lat   = exp_lat;
    exp_q.push_back(e);
    pulse_start();
    if (raise) ref_in = 1'b1;
    wait_pulse(n);
    check({name, "_cycles"}, n, exp_n);
    @(posedge clk);
    #1;
    check({name, "_busy_after"}, int'(busy), 0);
    ref_in = 1'b0;
    tick(14);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; ref_in = 1'b0;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_timeout", int'(timeout), 0);
    check("reset_latency", int'(latency), 0);
    tick(2);

    // Pulse seen n negedges after the start-sampling edge: latency+2 when ref rises right after it.
    run_meas("delay1", 1, 1'b1, 1'b0, 1, 3);
    run_meas("delay0", 0, 1'b1, 1'b0, 0, 2);
    run_meas("delay5", 5, 1'b1, 1'b0, 5, 7);
    run_meas("delay8", 8, 1'b1, 1'b0, 8, 10);
    run_meas("delay9_timeout", 9, 1'b1, 1'b1, 8, 10);
    check("latency_hold_timeout", int'(latency), 8);
    run_meas("arm_timeout", 0, 1'b0, 1'b1, 8, 10);
    check("latency_hold_arm_timeout", int'(latency), 8);

    // Reset two cycles into MEASURE: no pulse, latency cleared.
    sel = 5;
    pulse_start();
    ref_in = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_latency", int'(latency), 0);
    ref_in = 1'b0;
    tick(14);
    run_meas("after_rst", 5, 1'b1, 1'b0, 5, 7);

    // Abort during ARM.
    sel = 0;
    pulse_start();
    tick(2);
    pulse_abort();
    @(negedge clk);
    check("abort_arm_busy", int'(busy), 0);
    check("abort_arm_latency", int'(latency), 5);
    tick(14);

    // Abort during MEASURE; the late dly rise lands in IDLE and must be ignored.
    sel = 5;
    pulse_start();
    ref_in = 1'b1;
    tick(2);
    pulse_abort();
    @(negedge clk);
    check("abort_meas_busy", int'(busy), 0);
    check("abort_meas_latency", int'(latency), 5);
    ref_in = 1'b0;
    tick(14);

    // start together with abort in IDLE, then abort alone in IDLE.
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("start_abort_idle_busy", int'(busy), 0);
    pulse_abort();
    @(negedge clk);
    check("abort_idle_busy", int'(busy), 0);
    check("abort_idle_latency", int'(latency), 5);
    tick(2);

    // Extra start and a second ref rise during MEASURE are ignored.
    begin
      int   n;
      exp_t e;
      sel     = 5;
      e.is_to = 1'b0;
      e.lat   = 5;
      exp_q.push_back(e);
      pulse_start();
      ref_in = 1'b1;
      tick(1);
      pulse_start();
      ref_in = 1'b0;
      tick(1);
      ref_in = 1'b1;
      wait_pulse(n);
      check("ignore_restart_cycles", n, 4);
      ref_in = 1'b0;
      tick(16);
      check("ignore_restart_busy", int'(busy), 0);
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
